// File: rtl/regs_pkg.sv
// Shared types, defaults and helpers for the multi-port register file.
package regs_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ZERO_REG = 1;
  localparam int DEF_BYPASS   = 1;

  function automatic logic addr_in_range(
    input int unsigned addr,
    input int unsigned depth
  );
    return addr < depth;
  endfunction

endpackage

// File: rtl/regs_read_port.sv
// One registered read port: entry select, zero/range masking, write bypass.
module regs_read_port
  import regs_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = $clog2(DEF_DEPTH),
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = DEF_BYPASS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_rd_fire,
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic [DEPTH*DATA_W-1:0] i_mem_flat,
  input  logic                    i_wr_fire,
  input  logic [ADDR_W-1:0]       i_wr_addr,
  input  logic [DATA_W-1:0]       i_wr_data,
  output logic [DATA_W-1:0]       o_rd_data
);

  logic [DATA_W-1:0] w_mem;
  logic [DATA_W-1:0] w_next;
  logic              w_zero;
  logic              w_bypass;
  logic [DATA_W-1:0] r_data;

  always_comb begin
    w_mem = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_addr == ADDR_W'(i)) begin
        w_mem = i_mem_flat[i*DATA_W +: DATA_W];
      end
    end
  end

  // i_wr_fire already excludes dropped writes, so bypass never leaks them
  assign w_zero = ((ZERO_REG != 0) && (i_addr == '0))
               || !addr_in_range(32'(i_addr), DEPTH);
  assign w_bypass = (BYPASS != 0) && i_wr_fire
                 && (i_wr_addr == i_addr);

  always_comb begin
    w_next = w_mem;
    if (w_zero) begin
      w_next = '0;
    end else if (w_bypass) begin
      w_next = i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_rd_fire) begin
      r_data <= w_next;
    end
  end

  assign o_rd_data = r_data;

endmodule

// File: rtl/regs_multi.sv
// Multi-read-port register file with a sequential clear engine.
module regs_multi
  import regs_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int NUM_RD   = DEF_NUM_RD,
  parameter  int ZERO_REG = DEF_ZERO_REG,
  parameter  int BYPASS   = DEF_BYPASS,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic                     rs_rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rs_addr,
  output logic [NUM_RD*DATA_W-1:0] rs_rd_data,
  output logic                     rs_rd_valid,
  input  logic [ADDR_W-1:0]        rd,
  input  logic [DATA_W-1:0]        rd_wr_data,
  input  logic                     rd_wr_en
);

  state_e                    r_state;
  logic [ADDR_W-1:0]         r_clr_cnt;
  logic                      r_valid;
  logic [DATA_W-1:0]         r_mem [DEPTH];
  logic [DEPTH*DATA_W-1:0]   w_mem_flat;
  logic                      w_idle;
  logic                      w_wr_fire;
  logic                      w_rd_fire;

  assign w_idle = (r_state == ST_IDLE);

  // A clear request beats a write in the same cycle; reads still go ahead
  assign w_wr_fire = w_idle && rd_wr_en && !clr_req
                  && addr_in_range(32'(rd), DEPTH)
                  && !((ZERO_REG != 0) && (rd == '0));
  assign w_rd_fire = w_idle && rs_rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= w_rd_fire;
      unique case (r_state)
        ST_CLEAR: begin
          if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!w_idle) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_fire) begin
      r_mem[rd] <= rd_wr_data;
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_flat
    assign w_mem_flat[e*DATA_W +: DATA_W] = r_mem[e];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regs_read_port #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_port (
      .clk       (clk),
      .rst       (rst),
      .i_rd_fire (w_rd_fire),
      .i_addr    (rs_addr[p*ADDR_W +: ADDR_W]),
      .i_mem_flat(w_mem_flat),
      .i_wr_fire (w_wr_fire),
      .i_wr_addr (rd),
      .i_wr_data (rd_wr_data),
      .o_rd_data (rs_rd_data[p*DATA_W +: DATA_W])
    );
  end

  assign busy        = (r_state == ST_CLEAR);
  assign rs_rd_valid = r_valid;

endmodule

// File: tb/tb_regs_multi.sv
// Directed bench: default, no-bypass and DEPTH=24/3-port/no-zero configs.
module tb_regs_multi;

  logic        clk;
  logic        rst;
  logic        rst24;
  logic        clr_req;
  logic        rs_rd_en;
  logic [14:0] rs_addr3;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic        we;

  logic        busy_a, busy_b, busy_c;
  logic        valid_a, valid_b, valid_c;
  logic [63:0] data_a, data_b;
  logic [95:0] data_c;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] mdl [32];

  regs_multi u_dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a),
    .rs_rd_en(rs_rd_en), .rs_addr(rs_addr3[9:0]),
    .rs_rd_data(data_a), .rs_rd_valid(valid_a),
    .rd(rd), .rd_wr_data(wd), .rd_wr_en(we)
  );

  regs_multi #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b),
    .rs_rd_en(rs_rd_en), .rs_addr(rs_addr3[9:0]),
    .rs_rd_data(data_b), .rs_rd_valid(valid_b),
    .rd(rd), .rd_wr_data(wd), .rd_wr_en(we)
  );

  regs_multi #(.DEPTH(24), .NUM_RD(3), .ZERO_REG(0)) u_d24 (
    .clk(clk), .rst(rst24), .clr_req(clr_req), .busy(busy_c),
    .rs_rd_en(rs_rd_en), .rs_addr(rs_addr3),
    .rs_rd_data(data_c), .rs_rd_valid(valid_c),
    .rd(rd), .rd_wr_data(wd), .rd_wr_en(we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rd = a;
    wd = d;
    we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rdp(input logic [4:0] a0, input logic [4:0] a1,
                     input logic [4:0] a2);
    rs_addr3 = {a2, a1, a0};
    rs_rd_en = 1'b1;
    step();
    rs_rd_en = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b1;
    rst24 = 1'b1;
    clr_req = 1'b0;
    rs_rd_en = 1'b0;
    rs_addr3 = '0;
    rd = '0;
    wd = '0;
    we = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy_a), 32'd1);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_data", data_a[31:0], 32'd0);

    rst = 1'b0;
    n = 0;
    while (busy_a && n < 100) begin
      step();
      n++;
    end
    chk("init_clear_len", 32'(n), 32'd32);
    chk("init_nb_busy", 32'(busy_b), 32'd0);
    for (int i = 0; i < 32; i += 2) begin
      rdp(5'(i), 5'(i + 1), 5'd0);
      chk("init_rd_p0", data_a[31:0], 32'd0);
      chk("init_rd_p1", data_a[63:32], 32'd0);
    end
    chk("init_valid", 32'(valid_a), 32'd1);

    wr(5'd5, 32'hDEADBEEF);
    rdp(5'd5, 5'd0, 5'd0);
    chk("x5_p0", data_a[31:0], 32'hDEADBEEF);
    chk("x0_p1", data_a[63:32], 32'd0);
    chk("x5_valid", 32'(valid_a), 32'd1);
    step();
    chk("x5_valid_drop", 32'(valid_a), 32'd0);
    chk("x5_hold", data_a[31:0], 32'hDEADBEEF);
    wr(5'd0, 32'hFFFFFFFF);
    rdp(5'd0, 5'd5, 5'd0);
    chk("x0_wr_disc", data_a[31:0], 32'd0);
    chk("x5_p1", data_a[63:32], 32'hDEADBEEF);

    wr(5'd7, 32'hAAAA5555);
    rd = 5'd7;
    wd = 32'h12345678;
    we = 1'b1;
    rdp(5'd7, 5'd7, 5'd0);
    we = 1'b0;
    chk("byp_p0", data_a[31:0], 32'h12345678);
    chk("byp_p1", data_a[63:32], 32'h12345678);
    chk("nobyp_p0", data_b[31:0], 32'hAAAA5555);
    rdp(5'd7, 5'd0, 5'd0);
    chk("nobyp_after", data_b[31:0], 32'h12345678);

    for (int i = 1; i < 32; i++) begin
      mdl[i] = $urandom | 32'h1;
      wr(5'(i), mdl[i]);
    end
    rdp(5'd3, 5'd17, 5'd0);
    chk("fill_x3", data_a[31:0], mdl[3]);
    chk("fill_x17", data_a[63:32], mdl[17]);

    clr_req = 1'b1;
    rd = 5'd3;
    wd = 32'h33333333;
    we = 1'b1;
    rs_addr3 = {5'd0, 5'd0, 5'd3};
    rs_rd_en = 1'b1;
    step();
    chk("clr_rd_valid", 32'(valid_a), 32'd1);
    chk("clr_rd_prewr", data_a[31:0], mdl[3]);
    chk("clr_busy", 32'(busy_a), 32'd1);
    n = 0;
    bad = 0;
    while (busy_a && n < 100) begin
      step();
      n++;
      if (valid_a !== 1'b0 || data_a[31:0] !== mdl[3]) bad++;
    end
    clr_req = 1'b0;
    we = 1'b0;
    rs_rd_en = 1'b0;
    chk("clr_len", 32'(n), 32'd32);
    chk("clr_ignore", 32'(bad), 32'd0);
    for (int i = 0; i < 32; i += 2) begin
      rdp(5'(i), 5'(i + 1), 5'd0);
      chk("clr_rd_p0", data_a[31:0], 32'd0);
      chk("clr_rd_p1", data_a[63:32], 32'd0);
    end

    wr(5'd9, 32'h99999999);
    rdp(5'd9, 5'd0, 5'd0);
    chk("x9_rd", data_a[31:0], 32'h99999999);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (10) step();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_a), 32'd1);
    chk("arst_data", data_a[31:0], 32'd0);
    chk("arst_valid", 32'(valid_a), 32'd0);
    step();
    rst = 1'b0;
    n = 0;
    while (busy_a && n < 100) begin
      step();
      n++;
    end
    chk("arst_clear_len", 32'(n), 32'd32);
    rdp(5'd9, 5'd5, 5'd0);
    chk("arst_x9", data_a[31:0], 32'd0);

    rst24 = 1'b0;
    n = 0;
    while (busy_c && n < 100) begin
      step();
      n++;
    end
    chk("d24_clear_len", 32'(n), 32'd24);
    wr(5'd0, 32'hA5A5A5A5);
    wr(5'd30, 32'h30303030);
    wr(5'd23, 32'h00000023);
    rdp(5'd0, 5'd23, 5'd30);
    chk("d24_x0", data_c[31:0], 32'hA5A5A5A5);
    chk("d24_x23", data_c[63:32], 32'h00000023);
    chk("d24_x30", data_c[95:64], 32'd0);
    chk("d24_valid", 32'(valid_c), 32'd1);
    chk("dflt_x0", data_a[31:0], 32'd0);
    rd = 5'd30;
    wd = 32'h3A3A3A3A;
    we = 1'b1;
    rdp(5'd30, 5'd23, 5'd23);
    we = 1'b0;
    chk("d24_byp_oor", data_c[31:0], 32'd0);
    chk("d24_same_p1", data_c[63:32], 32'h00000023);
    chk("d24_same_p2", data_c[95:64], 32'h00000023);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
